// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: E-stage operand
// forwarding selects and the MDU occupancy FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    // M beats W; x0 never forwards since it always reads as zero
    function automatic logic [1:0] fwd_sel(input logic src_nz, input logic hit_m,
                                           input logic hit_w);
        if (!src_nz)    return FWD_RF;
        else if (hit_m) return FWD_MEM;
        else if (hit_w) return FWD_WB;
        else            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module hazard_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage pipeline with a multi-cycle
// MUL/DIV unit held in E: forwarding, load-use stall, branch flush, MDU freeze.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MDU_MODE = 0,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              load_e,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              pc_src_e,
    input  logic              mdu_op_e,
    input  logic              mdu_done,
    input  logic              cnt_clr,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  lw_cnt,
    output logic [CNT_W-1:0]  mdu_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int MCW = $clog2(MDU_LAT);
    localparam logic [MCW-1:0] MCNT_LAST = MCW'(MDU_LAT - 1);

    mdu_state_t     state, state_n;
    logic [MCW-1:0] mcnt, mcnt_n;
    logic           finish, finish_i, stall_raw;
    logic           mdu_stall, lw_hit, lw_stall;

    assign finish   = (MDU_MODE == 0) ? (mcnt == MCNT_LAST) : mdu_done;
    assign finish_i = (MDU_MODE == 1) && mdu_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MDU_IDLE;
            mcnt  <= '0;
        end else begin
            state <= state_n;
            mcnt  <= mcnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        mcnt_n    = mcnt;
        stall_raw = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (mdu_op_e && !finish_i) begin
                    state_n   = MDU_BUSY;
                    mcnt_n    = MCW'(1);
                    stall_raw = 1'b1;
                end
            end
            MDU_BUSY: begin
                mcnt_n = mcnt + 1'b1;
                // mdu_op_e on the finish cycle belongs to the op that is leaving E
                if (finish) state_n = MDU_IDLE;
                else        stall_raw = 1'b1;
            end
            default: state_n = MDU_IDLE;
        endcase
    end

    assign mdu_stall = !rst && stall_raw;
    assign mdu_busy  = !rst && (state == MDU_BUSY);

    assign lw_hit   = load_e && (rd_e != '0) && ((rs1_d == rd_e) || (rs2_d == rd_e));
    assign lw_stall = !rst && lw_hit && !mdu_stall;

    // A taken branch discards the stalled D instruction, so fetch must not hold
    assign stall_f = (lw_stall && !pc_src_e) || mdu_stall;
    assign stall_d = stall_f;
    assign stall_e = mdu_stall;
    assign flush_d = rst || pc_src_e;
    assign flush_e = rst || pc_src_e || lw_stall;
    assign flush_m = rst || mdu_stall;

    always_comb begin
        forward_ae = FWD_RF;
        forward_be = FWD_RF;
        if (!rst) begin
            forward_ae = fwd_sel(rs1_e != '0, reg_write_m && (rd_m == rs1_e),
                                 reg_write_w && (rd_w == rs1_e));
            forward_be = fwd_sel(rs2_e != '0, reg_write_m && (rd_m == rs2_e),
                                 reg_write_w && (rd_w == rs2_e));
        end
    end

    hazard_sat_cnt #(.CNT_W(CNT_W)) u_lw_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(lw_stall && !pc_src_e), .q(lw_cnt)
    );

    hazard_sat_cnt #(.CNT_W(CNT_W)) u_mdu_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(mdu_stall), .q(mdu_cnt)
    );

    hazard_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(!rst && pc_src_e), .q(flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: fixed-latency, handshake-mode and 2-bit-counter
// instances driven from shared inputs and compared against a cycle-level model.
module tb_pipeline_hazard_ctrl;

    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0, rd_e = '0, rd_m = '0, rd_w = '0;
    logic       load_e = 0, reg_write_m = 0, reg_write_w = 0, pc_src_e = 0;
    logic       mdu_op_e = 0, mdu_op1 = 0, mdu_done = 0, cnt_clr = 0;

    logic        stall_f0, stall_d0, stall_e0, flush_d0, flush_e0, flush_m0, busy0;
    logic [1:0]  fa0, fb0;
    logic [15:0] lwc0, mdc0, flc0;
    logic        stall_f1, stall_d1, stall_e1, flush_d1, flush_e1, flush_m1, busy1;
    logic [1:0]  fa1, fb1;
    logic [15:0] lwc1, mdc1, flc1;
    logic        stall_f2, stall_d2, stall_e2, flush_d2, flush_e2, flush_m2, busy2;
    logic [1:0]  fa2, fb2;
    logic [1:0]  lwc2, mdc2, flc2;

    pipeline_hazard_ctrl #(.REG_AW(5), .MDU_MODE(0), .MDU_LAT(LAT), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .load_e(load_e), .reg_write_m(reg_write_m),
        .reg_write_w(reg_write_w), .pc_src_e(pc_src_e), .mdu_op_e(mdu_op_e), .mdu_done(mdu_done),
        .cnt_clr(cnt_clr), .stall_f(stall_f0), .stall_d(stall_d0), .stall_e(stall_e0),
        .flush_d(flush_d0), .flush_e(flush_e0), .flush_m(flush_m0), .forward_ae(fa0),
        .forward_be(fb0), .mdu_busy(busy0), .lw_cnt(lwc0), .mdu_cnt(mdc0), .flush_cnt(flc0));

    pipeline_hazard_ctrl #(.REG_AW(5), .MDU_MODE(1), .MDU_LAT(LAT), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .load_e(load_e), .reg_write_m(reg_write_m),
        .reg_write_w(reg_write_w), .pc_src_e(pc_src_e), .mdu_op_e(mdu_op1), .mdu_done(mdu_done),
        .cnt_clr(cnt_clr), .stall_f(stall_f1), .stall_d(stall_d1), .stall_e(stall_e1),
        .flush_d(flush_d1), .flush_e(flush_e1), .flush_m(flush_m1), .forward_ae(fa1),
        .forward_be(fb1), .mdu_busy(busy1), .lw_cnt(lwc1), .mdu_cnt(mdc1), .flush_cnt(flc1));

    pipeline_hazard_ctrl #(.REG_AW(5), .MDU_MODE(0), .MDU_LAT(LAT), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .load_e(load_e), .reg_write_m(reg_write_m),
        .reg_write_w(reg_write_w), .pc_src_e(pc_src_e), .mdu_op_e(mdu_op_e), .mdu_done(mdu_done),
        .cnt_clr(cnt_clr), .stall_f(stall_f2), .stall_d(stall_d2), .stall_e(stall_e2),
        .flush_d(flush_d2), .flush_e(flush_e2), .flush_m(flush_m2), .forward_ae(fa2),
        .forward_be(fb2), .mdu_busy(busy2), .lw_cnt(lwc2), .mdu_cnt(mdc2), .flush_cnt(flc2));

    typedef struct {
        int rst, rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        int load, rwm, rww, pc, op, op1, done, clr;
    } in_t;

    typedef struct {
        int rs1_e, rs2_e, rd_m, rd_w, rd_e, rs1_d, rs2_d, rwm, rww, load, pc;
        int fa, fb, st, fd, fe;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // model state: cycles the current op has spent in E, handshake busy flag, counters
    int age0 = 0, bsy1 = 0;
    int m_lw0 = 0, m_md0 = 0, m_fl0 = 0, m_md1 = 0, m_lw2 = 0, m_md2 = 0, m_fl2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fwd_ref(int src, int rdm, int rdw, int wm, int ww);
        if (src == 0) return 0;
        if (wm != 0 && rdm == src) return 2;
        if (ww != 0 && rdw == src) return 1;
        return 0;
    endfunction

    function automatic int sat(int c, int mx);
        return (c >= mx) ? mx : c + 1;
    endfunction

    function automatic in_t idle();
        in_t v;
        v = '{default: 0};
        return v;
    endfunction

    task automatic apply(input in_t v);
        int ms0, ms1, lw, r;
        @(negedge clk);
        rst = v.rst[0]; rs1_d = 5'(v.rs1_d); rs2_d = 5'(v.rs2_d); rs1_e = 5'(v.rs1_e);
        rs2_e = 5'(v.rs2_e); rd_e = 5'(v.rd_e); rd_m = 5'(v.rd_m); rd_w = 5'(v.rd_w);
        load_e = v.load[0]; reg_write_m = v.rwm[0]; reg_write_w = v.rww[0];
        pc_src_e = v.pc[0]; mdu_op_e = v.op[0]; mdu_op1 = v.op1[0]; mdu_done = v.done[0];
        cnt_clr = v.clr[0];
        #1;
        r   = v.rst;
        ms0 = (r == 0 && (age0 > 0 || v.op != 0) && age0 + 1 < LAT) ? 1 : 0;
        ms1 = (r == 0 && (bsy1 != 0 || v.op1 != 0) && v.done == 0) ? 1 : 0;
        lw  = (r == 0 && ms0 == 0 && v.load != 0 && v.rd_e != 0 &&
               (v.rs1_d == v.rd_e || v.rs2_d == v.rd_e)) ? 1 : 0;
        chk("fwd_a", 32'(fa0), 32'(r != 0 ? 0 : fwd_ref(v.rs1_e, v.rd_m, v.rd_w, v.rwm, v.rww)));
        chk("fwd_b", 32'(fb0), 32'(r != 0 ? 0 : fwd_ref(v.rs2_e, v.rd_m, v.rd_w, v.rwm, v.rww)));
        chk("stall_f", 32'(stall_f0), 32'((lw != 0 && v.pc == 0) || ms0 != 0));
        chk("stall_d", 32'(stall_d0), 32'((lw != 0 && v.pc == 0) || ms0 != 0));
        chk("stall_e", 32'(stall_e0), 32'(ms0));
        chk("flush_d", 32'(flush_d0), 32'(r != 0 || v.pc != 0));
        chk("flush_e", 32'(flush_e0), 32'(r != 0 || v.pc != 0 || lw != 0));
        chk("flush_m", 32'(flush_m0), 32'(r != 0 || ms0 != 0));
        chk("mdu_busy", 32'(busy0), 32'(r == 0 && age0 > 0));
        chk("lw_cnt", 32'(lwc0), 32'(m_lw0));
        chk("mdu_cnt", 32'(mdc0), 32'(m_md0));
        chk("flush_cnt", 32'(flc0), 32'(m_fl0));
        chk("h_stall_e", 32'(stall_e1), 32'(ms1));
        chk("h_busy", 32'(busy1), 32'(r == 0 && bsy1 != 0));
        chk("h_mdu_cnt", 32'(mdc1), 32'(m_md1));
        chk("s_lw_cnt", 32'(lwc2), 32'(m_lw2));
        chk("s_mdu_cnt", 32'(mdc2), 32'(m_md2));
        chk("s_flush_cnt", 32'(flc2), 32'(m_fl2));
        if (r != 0) begin
            age0 = 0; bsy1 = 0;
            m_lw0 = 0; m_md0 = 0; m_fl0 = 0; m_md1 = 0; m_lw2 = 0; m_md2 = 0; m_fl2 = 0;
        end else begin
            if (age0 > 0 || v.op != 0) age0 = (age0 + 1 == LAT) ? 0 : age0 + 1;
            bsy1 = (bsy1 != 0 || v.op1 != 0) && v.done == 0 ? 1 : 0;
            if (v.clr != 0) begin
                m_lw0 = 0; m_md0 = 0; m_fl0 = 0; m_md1 = 0; m_lw2 = 0; m_md2 = 0; m_fl2 = 0;
            end else begin
                if (lw != 0 && v.pc == 0) begin m_lw0 = sat(m_lw0, 65535); m_lw2 = sat(m_lw2, 3); end
                if (ms0 != 0) begin m_md0 = sat(m_md0, 65535); m_md2 = sat(m_md2, 3); end
                if (v.pc != 0) begin m_fl0 = sat(m_fl0, 65535); m_fl2 = sat(m_fl2, 3); end
                if (ms1 != 0) m_md1 = sat(m_md1, 65535);
            end
        end
    endtask

    vec_t tbl[11];
    in_t  v;

    initial begin
        tbl[0]  = '{5, 0, 5, 5, 0, 0, 0, 1, 1, 0, 0,  2, 0, 0, 0, 0};
        tbl[1]  = '{5, 0, 5, 5, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0};
        tbl[3]  = '{0, 9, 3, 9, 0, 0, 0, 1, 1, 0, 0,  0, 1, 0, 0, 0};
        tbl[4]  = '{0, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 7, 0, 7, 0, 0, 1, 0,  0, 0, 1, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 7, 7, 0, 0, 0, 1, 1,  0, 0, 0, 1, 1};
        tbl[8]  = '{0, 0, 0, 0, 7, 3, 4, 0, 0, 1, 0,  0, 0, 0, 0, 0};
        tbl[9]  = '{31, 15, 31, 15, 0, 0, 0, 1, 1, 0, 0, 2, 1, 0, 0, 0};
        tbl[10] = '{16, 0, 0, 16, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0};

        // reset state
        v = idle(); v.rst = 1; v.op = 1; v.pc = 1; v.load = 1; v.rd_e = 3; v.rs1_d = 3;
        apply(v);
        apply(v);

        // forwarding / load-use / branch table
        v = idle(); v.clr = 1; apply(v);
        foreach (tbl[i]) begin
            v = idle();
            v.rs1_e = tbl[i].rs1_e; v.rs2_e = tbl[i].rs2_e; v.rd_m = tbl[i].rd_m;
            v.rd_w = tbl[i].rd_w; v.rd_e = tbl[i].rd_e; v.rs1_d = tbl[i].rs1_d;
            v.rs2_d = tbl[i].rs2_d; v.rwm = tbl[i].rwm; v.rww = tbl[i].rww;
            v.load = tbl[i].load; v.pc = tbl[i].pc;
            apply(v);
            chk($sformatf("tbl%0d_fa", i), 32'(fa0), 32'(tbl[i].fa));
            chk($sformatf("tbl%0d_fb", i), 32'(fb0), 32'(tbl[i].fb));
            chk($sformatf("tbl%0d_stall", i), 32'(stall_f0), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_flush_d", i), 32'(flush_d0), 32'(tbl[i].fd));
            chk($sformatf("tbl%0d_flush_e", i), 32'(flush_e0), 32'(tbl[i].fe));
        end
        apply(idle());
        chk("tbl_lw_total", 32'(lwc0), 32'd1);
        chk("tbl_flush_total", 32'(flc0), 32'd1);

        // fixed latency: two back-to-back ops, 3 stall cycles each
        v = idle(); v.clr = 1; apply(v);
        for (int i = 0; i < 8; i++) begin
            v = idle(); v.op = 1; apply(v);
            chk("fix_stall_pattern", 32'(stall_e0), 32'((i % 4) != 3));
            if (i == 4) chk("fix_cnt_first", 32'(mdc0), 32'd3);
        end
        apply(idle());
        chk("fix_cnt_both", 32'(mdc0), 32'd6);

        // handshake: done after 6 cycles, then done on the first cycle
        v = idle(); v.clr = 1; apply(v);
        for (int i = 0; i < 7; i++) begin
            v = idle(); v.op1 = 1; v.done = (i == 6) ? 1 : 0; apply(v);
            chk("hs_stall_pattern", 32'(stall_e1), 32'(i < 6));
        end
        apply(idle());
        chk("hs_cnt", 32'(mdc1), 32'd6);
        v = idle(); v.op1 = 1; v.done = 1; apply(v);
        chk("hs_done_first", 32'(stall_e1), 32'd0);
        apply(idle());
        chk("hs_cnt_unchanged", 32'(mdc1), 32'd6);

        // reset in the second BUSY cycle aborts the op
        v = idle(); v.op = 1; apply(v); apply(v);
        v.rst = 1; apply(v);
        apply(idle());
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_stall", 32'(stall_e0), 32'd0);
        chk("rst_cnt", 32'(mdc0), 32'd0);

        // 2-bit saturation and clear-beats-increment
        for (int i = 0; i < 5; i++) begin v = idle(); v.pc = 1; apply(v); end
        apply(idle());
        chk("sat_flush2", 32'(flc2), 32'd3);
        chk("sat_flush16", 32'(flc0), 32'd5);
        v = idle(); v.pc = 1; v.clr = 1; apply(v);
        apply(idle());
        chk("clr_wins2", 32'(flc2), 32'd0);
        chk("clr_wins16", 32'(flc0), 32'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            v = idle();
            v.rs1_d = $urandom_range(0, 7); v.rs2_d = $urandom_range(0, 7);
            v.rs1_e = $urandom_range(0, 7); v.rs2_e = $urandom_range(0, 7);
            v.rd_e = $urandom_range(0, 7); v.rd_m = $urandom_range(0, 7);
            v.rd_w = ($urandom % 8 == 0) ? 31 : $urandom_range(0, 7);
            v.rwm = $urandom % 2; v.rww = $urandom % 2;
            v.load = ($urandom % 3 == 0) ? 1 : 0;
            v.pc = ($urandom % 6 == 0) ? 1 : 0;
            v.clr = ($urandom % 60 == 0) ? 1 : 0;
            v.rst = ($urandom % 90 == 0) ? 1 : 0;
            if (age0 > 0 || $urandom % 6 == 0) begin v.op = 1; v.load = 0; v.pc = 0; end
            v.op1 = (bsy1 != 0 || $urandom % 5 == 0) ? 1 : 0;
            v.done = ($urandom % 4 == 0) ? 1 : 0;
            apply(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
